// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared width, reset PC default and FSM encoding for the fetch unit
package pc_fetch_pkg;
  localparam int PC_XLEN = 32;
  localparam logic [PC_XLEN-1:0] PC_RESET_DEFAULT = '0;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STALL = 2'd2, HALT = 2'd3} pc_state_t;
endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: control inputs and PC/status outputs between the CPU core and pc_fetch
interface pc_fetch_if #(parameter int XLEN = pc_fetch_pkg::PC_XLEN);
  logic            start;
  logic            stall;
  logic [XLEN-1:0] seq_pc_i;
  logic            br_taken_i;
  logic [XLEN-1:0] br_target_i;
  logic            jmp_i;
  logic [XLEN-1:0] jmp_target_i;
  logic            halt_i;
  logic [XLEN-1:0] pc_o;
  logic            valid_o;
  logic [1:0]      state_o;
  logic [31:0]     retired_o;
  logic            misalign_o;
  modport master (
    output start, stall, seq_pc_i, br_taken_i, br_target_i, jmp_i, jmp_target_i, halt_i,
    input  pc_o, valid_o, state_o, retired_o, misalign_o
  );
  modport slave (
    input  start, stall, seq_pc_i, br_taken_i, br_target_i, jmp_i, jmp_target_i, halt_i,
    output pc_o, valid_o, state_o, retired_o, misalign_o
  );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC priority pending > jump > branch > sequential; redirect targets
// are word-aligned by clearing bits[1:0] unless PC_FETCH_ALIGN_CHECK_EN keeps them raw for checking
module pc_next_sel #(parameter int XLEN = pc_fetch_pkg::PC_XLEN) (
  input  logic            pend_v,
  input  logic [XLEN-1:0] pend_pc,
  input  logic            jmp,
  input  logic [XLEN-1:0] jmp_pc,
  input  logic            br,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] seq_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            redir
);
  logic [XLEN-1:0] tgt;
  always_comb begin
    tgt   = pend_v ? pend_pc : jmp ? jmp_pc : br_pc;
    redir = pend_v | jmp | br;
  end
`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign next_pc = redir ? tgt : seq_pc;
`else
  assign next_pc = redir ? {tgt[XLEN-1:2], 2'b00} : seq_pc;
`endif
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program-counter FSM with 1-entry pending redirect across stalls;
// PC_FETCH_ALIGN_CHECK_EN halts on misaligned redirect targets with a sticky flag
module pc_fetch import pc_fetch_pkg::*; #(
  parameter int              XLEN     = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = PC_RESET_DEFAULT
) (
  input logic       clk,
  input logic       rst_n,
  pc_fetch_if.slave bus
);
  pc_state_t       state, state_nx;
  logic [XLEN-1:0] pc, pend_pc, sel_pc;
  logic [31:0]     retired;
  logic            pend_v, sel_redir, adv, cap, bad;
  pc_next_sel #(.XLEN(XLEN)) u_sel (
    .pend_v (pend_v),
    .pend_pc(pend_pc),
    .jmp    (bus.jmp_i),
    .jmp_pc (bus.jmp_target_i),
    .br     (bus.br_taken_i),
    .br_pc  (bus.br_target_i),
    .seq_pc (bus.seq_pc_i),
    .next_pc(sel_pc),
    .redir  (sel_redir)
  );
`ifdef PC_FETCH_ALIGN_CHECK_EN
  logic mis;
  assign bad = sel_redir && |sel_pc[1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mis <= 1'b0;
    else if (state != HALT && state_nx == HALT && bad && !(state == RUN && bus.halt_i)) mis <= 1'b1;
  assign bus.misalign_o = mis;
`else
  assign bad = 1'b0;
  assign bus.misalign_o = 1'b0;
`endif
  // a stall in RUN takes precedence over halt and parks any redirect in the pending slot
  always_comb begin
    state_nx = state;
    adv = 1'b0;
    cap = 1'b0;
    case (state)
      IDLE: state_nx = bus.start ? RUN : IDLE;
      RUN: begin
        state_nx = bus.stall ? STALL : (bus.halt_i || bad) ? HALT : RUN;
        cap = bus.stall;
        adv = !bus.stall && !bus.halt_i && !bad;
      end
      STALL: begin
        state_nx = bus.stall ? STALL : (pend_v && bad) ? HALT : RUN;
        adv = !bus.stall && pend_v && !bad;
      end
      default: state_nx = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      pend_v  <= 1'b0;
      pend_pc <= '0;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (adv) pc <= sel_pc;
      if (cap) begin
        pend_v  <= sel_redir;
        pend_pc <= sel_pc;
      end else if (state == STALL && !bus.stall) pend_v <= 1'b0;
      if (adv || (state != HALT && state_nx == HALT)) retired <= retired + 32'd1;
    end
  assign bus.pc_o      = pc;
  assign bus.state_o   = state;
  assign bus.valid_o   = state == RUN || state == STALL;
  assign bus.retired_o = retired;
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed scenarios plus randomized traffic against a rule-level reference model
module tb_pc_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_st;
  logic [31:0] m_pc, m_ret;
  logic m_mis;
  logic [31:0] pend_q[$];
  pc_fetch_if bus();
  pc_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] fix(input logic [31:0] t);
`ifdef PC_FETCH_ALIGN_CHECK_EN
    return t;
`else
    return t & ~32'h3;
`endif
  endfunction
  function automatic bit bad(input logic [31:0] t);
`ifdef PC_FETCH_ALIGN_CHECK_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction
  task automatic model_reset();
    m_st = 0;
    m_pc = 32'h0;
    m_ret = 32'h0;
    m_mis = 1'b0;
    pend_q.delete();
  endtask
  // one clock edge of the fetch rules: 0 idle, 1 run, 2 stall, 3 halt
  task automatic model_step();
    logic [31:0] tgt;
    bit redir;
    redir = bus.jmp_i || bus.br_taken_i;
    tgt = fix(bus.jmp_i ? bus.jmp_target_i : bus.br_target_i);
    case (m_st)
      0: if (bus.start) m_st = 1;
      1: if (bus.stall) begin
           m_st = 2;
           if (redir) pend_q.push_back(tgt);
         end else if (bus.halt_i) begin
           m_st = 3;
           m_ret++;
         end else if (redir && bad(tgt)) begin
           m_st = 3;
           m_mis = 1'b1;
           m_ret++;
         end else begin
           m_pc = redir ? tgt : bus.seq_pc_i;
           m_ret++;
         end
      2: if (!bus.stall) begin
           m_st = 1;
           if (pend_q.size() > 0) begin
             tgt = pend_q.pop_front();
             if (bad(tgt)) begin
               m_st = 3;
               m_mis = 1'b1;
             end else m_pc = tgt;
             m_ret++;
           end
         end
      default: ;
    endcase
  endtask
  task automatic cmp(input string p);
    chk({p, "_pc"}, bus.pc_o, m_pc);
    chk({p, "_state"}, 32'(bus.state_o), m_st);
    chk({p, "_valid"}, 32'(bus.valid_o), 32'(m_st == 1 || m_st == 2));
    chk({p, "_retired"}, bus.retired_o, m_ret);
    chk({p, "_misalign"}, 32'(bus.misalign_o), 32'(m_mis));
  endtask
  task automatic drive(input logic st, input logic sl, input logic hl, input logic j,
                       input logic [31:0] jt, input logic b, input logic [31:0] bt);
    bus.start = st;
    bus.stall = sl;
    bus.halt_i = hl;
    bus.jmp_i = j;
    bus.jmp_target_i = jt;
    bus.br_taken_i = b;
    bus.br_target_i = bt;
    bus.seq_pc_i = m_pc + 32'd4;
  endtask
  task automatic step(input string p);
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp(p);
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    cmp("rst");
    chk("rst_pc_const", bus.pc_o, 32'h0);
    chk("rst_state_const", 32'(bus.state_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    step("start");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      step("seq");
    end
    chk("seq_pc12", bus.pc_o, 32'd12);
    chk("seq_ret3", bus.retired_o, 32'd3);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("seq");
    chk("seq_pc10", bus.pc_o, 32'h10);
    drive(0, 0, 0, 1, 32'h40, 1, 32'h80);
    step("jmp_br");
    chk("jmp_over_br", bus.pc_o, 32'h40);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 1, 32'h100);
      step("stall");
      chk("stall_pc_held", bus.pc_o, 32'h40);
      chk("stall_valid", 32'(bus.valid_o), 32'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step("unstall");
    chk("pending_load", bus.pc_o, 32'h100);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("post_pend");
    chk("pending_cleared", bus.pc_o, 32'h104);
    drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    step("top");
    drive(0, 0, 0, 0, 0, 0, 0);
    step("wrap");
    chk("wrap_pc0", bus.pc_o, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("seq");
    drive(0, 1, 1, 0, 0, 0, 0);
    step("stall_halt");
    chk("stall_beats_halt", 32'(bus.state_o), 32'd2);
    drive(0, 0, 0, 0, 0, 0, 0);
    step("resume");
    drive(0, 0, 1, 0, 0, 0, 0);
    step("halt");
    chk("halt_state", 32'(bus.state_o), 32'd3);
    chk("halt_valid", 32'(bus.valid_o), 32'd0);
    chk("halt_pc", bus.pc_o, 32'd4);
    drive(1, 0, 0, 1, 32'h300, 0, 0);
    step("halted");
    chk("halt_frozen", bus.pc_o, 32'd4);
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    step("start");
    drive(0, 1, 0, 1, 32'h200, 0, 0);
    step("stall_pend");
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    step("restart");
    drive(0, 0, 0, 0, 0, 0, 0);
    step("no_stale");
    chk("no_stale_redirect", bus.pc_o, 32'd4);
    drive(0, 0, 0, 1, 32'h42, 0, 0);
    step("mis");
`ifdef PC_FETCH_ALIGN_CHECK_EN
    chk("mis_flag", 32'(bus.misalign_o), 32'd1);
    chk("mis_state", 32'(bus.state_o), 32'd3);
    chk("mis_pc", bus.pc_o, 32'd4);
`else
    chk("mis_masked_pc", bus.pc_o, 32'h40);
    chk("mis_flag_tied", 32'(bus.misalign_o), 32'd0);
`endif
    for (int i = 0; i < 2000; i++) begin
      if ((m_st == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) do_reset();
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 3) == 0, $urandom);
      if ($urandom_range(0, 15) == 0) bus.seq_pc_i = $urandom;
      step("rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
